// File: rtl/dct_block_sched.sv
// dct_block_sched
//   Sequences the 2D 8x8 DCT datapath one block at a time. The datapath's
//   enable and done flags are sticky until its private reset, so every block
//   gets its own flush before it is enabled.
//
//   Ports
//     clk_i / rst_ni         clock, asynchronous active-low reset
//     in_valid_i/in_ready_o  upstream block handshake, in_data_i row-major 8x8
//     calc_reset_o           active-low reset to the datapath
//     calc_enable_o          datapath input enable
//     calc_data_o            block under computation, stable in CLEAR/RUN
//     calc_done_i            datapath result valid (sticky until calc_reset_o)
//     calc_result_i          datapath result block
//     out_valid_o/out_ready_i downstream handshake, out_data_o captured result
//     busy_o                 any block held anywhere in this unit
//     err_timeout_o          sticky, set when a block never completes
//     block_count_o          blocks delivered downstream, wraps
module dct_block_sched #(
    parameter int DATA_WIDTH     = 32,
    parameter int FLUSH_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [7:0][7:0][DATA_WIDTH-1:0]     in_data_i,
    output logic                                calc_reset_o,
    output logic                                calc_enable_o,
    output logic [7:0][7:0][DATA_WIDTH-1:0]     calc_data_o,
    input  logic                                calc_done_i,
    input  logic [7:0][7:0][DATA_WIDTH-1:0]     calc_result_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [7:0][7:0][DATA_WIDTH-1:0]     out_data_o,
    output logic                                busy_o,
    output logic                                err_timeout_o,
    output logic [15:0]                         block_count_o
);
    typedef logic [7:0][7:0][DATA_WIDTH-1:0] blk_t;
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN} state_e;

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic          in_full_q, in_full_d;
    blk_t          in_reg_q, in_reg_d;
    blk_t          calc_data_q, calc_data_d;
    logic          calc_reset_q, calc_reset_d;
    logic          calc_enable_q, calc_enable_d;
    logic          out_valid_q, out_valid_d;
    blk_t          out_data_q, out_data_d;
    logic          err_q, err_d;
    logic [15:0]   block_count_q, block_count_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        state_d       = state_q;
        in_full_d     = in_full_q;
        in_reg_d      = in_reg_q;
        calc_data_d   = calc_data_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        err_d         = err_q;
        block_count_d = block_count_q;
        flush_cnt_d   = flush_cnt_q;
        to_cnt_d      = to_cnt_q;

        // Downstream drain; a capture below on the same edge re-sets valid.
        if (out_valid_q && out_ready_i) begin
            out_valid_d   = 1'b0;
            block_count_d = block_count_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (in_full_q) begin
                    calc_data_d = in_reg_q;
                    in_full_d   = 1'b0;
                    flush_cnt_d = '0;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    to_cnt_d = '0;
                    state_d  = S_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (calc_done_i) begin
                    // Done is sticky, so waiting here for a free output
                    // slot loses nothing; the timeout is frozen meanwhile.
                    if (!out_valid_q || out_ready_i) begin
                        out_data_d  = calc_result_i;
                        out_valid_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Acceptance uses the registered full flag, so it never collides
        // with a dispatch on the same edge.
        if (in_valid_i && !in_full_q) begin
            in_reg_d  = in_data_i;
            in_full_d = 1'b1;
        end

        // Datapath controls are registered copies of the next state.
        calc_reset_d  = (state_d != S_CLEAR);
        calc_enable_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            in_full_q     <= 1'b0;
            in_reg_q      <= '0;
            calc_data_q   <= '0;
            calc_reset_q  <= 1'b0;
            calc_enable_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            err_q         <= 1'b0;
            block_count_q <= '0;
            flush_cnt_q   <= '0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            in_full_q     <= in_full_d;
            in_reg_q      <= in_reg_d;
            calc_data_q   <= calc_data_d;
            calc_reset_q  <= calc_reset_d;
            calc_enable_q <= calc_enable_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            err_q         <= err_d;
            block_count_q <= block_count_d;
            flush_cnt_q   <= flush_cnt_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign in_ready_o    = !in_full_q;
    assign calc_reset_o  = calc_reset_q;
    assign calc_enable_o = calc_enable_q;
    assign calc_data_o   = calc_data_q;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign err_timeout_o = err_q;
    assign block_count_o = block_count_q;
    assign busy_o        = (state_q != S_IDLE) || in_full_q || out_valid_q;

endmodule

// File: tb/tb_dct_block_sched.sv
// Bench for dct_block_sched: directed scenarios plus randomized traffic,
// checked every cycle against a block-level model kept here, with a
// scoreboard of expected results in arrival order.
module tb_dct_block_sched;
    localparam int DW      = 32;
    localparam int FLUSH   = 2;
    localparam int TIMEOUT = 64;

    typedef logic [7:0][7:0][DW-1:0] blk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    blk_t        in_data = '0;
    logic        calc_reset, calc_enable;
    blk_t        calc_data;
    logic        calc_done = 1'b0;
    blk_t        calc_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    blk_t        out_data;
    logic        busy, err_timeout;
    logic [15:0] block_count;

    dct_block_sched #(.DATA_WIDTH(DW), .FLUSH_CYCLES(FLUSH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .calc_reset_o(calc_reset), .calc_enable_o(calc_enable), .calc_data_o(calc_data),
        .calc_done_i(calc_done), .calc_result_i(calc_result),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .busy_o(busy), .err_timeout_o(err_timeout), .block_count_o(block_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Block-level model: phase 0 idle, 1 flushing, 2 running.
    int          m_phase, m_k, m_run;
    logic        m_full, m_ov, m_err;
    logic [15:0] m_count;
    blk_t        m_in, m_cd, m_od;
    blk_t        exp_q[$];
    blk_t        p_out_data;
    logic        p_calc_reset;
    int          n_flush = 0;
    int          dp_cnt;

    // Stand-in datapath transform: transpose with a fixed xor mask.
    function automatic blk_t xf(input blk_t d);
        blk_t o;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                o[r][c] = d[c][r] ^ 32'hDEADBEEF;
        return o;
    endfunction

    function automatic blk_t mk(input int base);
        blk_t o;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                o[r][c] = 32'(base + r * 8 + c);
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_blk(input string nm, input blk_t act, input blk_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            for (int i = 0; i < 64; i++)
                if (act[i/8][i%8] !== exp[i/8][i%8]) begin
                    $display("FAIL %s: word[%0d][%0d] got %h want %h (t=%0t)",
                             nm, i/8, i%8, act[i/8][i%8], exp[i/8][i%8], $time);
                    break;
                end
        end
    endtask

    task automatic reset_model();
        m_phase = 0; m_k = 0; m_run = 0;
        m_full = 0; m_ov = 0; m_err = 0; m_count = 0;
        m_in = '0; m_cd = '0; m_od = '0;
        exp_q.delete();
        p_out_data = '0; p_calc_reset = 0;
        calc_done = 0; calc_result = '0; dp_cnt = 0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_calc_reset", 32'(calc_reset), 0);
        chk("rst_calc_enable", 32'(calc_enable), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_count", 32'(block_count), 0);
        chk_blk("rst_out_data", out_data, '0);
        chk_blk("rst_calc_data", calc_data, '0);
    endtask

    // Advance the model by the edge that just happened, using the inputs
    // that were presented to it.
    task automatic model_step();
        logic old_full, old_ov;
        old_full = m_full;
        old_ov   = m_ov;
        if (old_ov && out_ready) begin
            m_count++;
            m_ov = 0;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: delivery with empty scoreboard (t=%0t)", $time);
            end else begin
                n_vec--;
                chk_blk("sb_order", p_out_data, exp_q.pop_front());
            end
        end
        case (m_phase)
            0: if (old_full) begin
                m_cd = m_in; m_full = 0; m_k = FLUSH; m_phase = 1;
            end
            1: begin
                m_k--;
                if (m_k == 0) begin m_phase = 2; m_run = 0; end
            end
            default: begin
                if (calc_done) begin
                    if (!old_ov || out_ready) begin
                        m_ov = 1; m_od = xf(m_cd); m_phase = 0;
                    end
                end else begin
                    m_run++;
                    if (m_run == TIMEOUT) begin m_err = 1; m_phase = 0; end
                end
            end
        endcase
        if (in_valid && !old_full) begin
            m_in = in_data; m_full = 1;
            if (!in_data[0][0][31]) exp_q.push_back(xf(in_data));
        end
    endtask

    // One clock: step model, compare, then update the datapath stand-in.
    task automatic cycle();
        @(negedge clk);
        model_step();
        chk("calc_reset", 32'(calc_reset), 32'(m_phase != 1));
        chk("calc_enable", 32'(calc_enable), 32'(m_phase == 2));
        chk("in_ready", 32'(in_ready), 32'(!m_full));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("busy", 32'(busy), 32'(m_phase != 0 || m_full || m_ov));
        chk("err_timeout", 32'(err_timeout), 32'(m_err));
        chk("block_count", 32'(block_count), 32'(m_count));
        chk_blk("out_data", out_data, m_od);
        chk_blk("calc_data", calc_data, m_cd);
        if (p_calc_reset && !calc_reset) n_flush++;
        p_calc_reset = calc_reset;
        // Datapath: word[0][0] bit31 = never finish, bits[3:0]+1 = latency.
        if (!calc_reset) begin
            calc_done = 0; dp_cnt = 0;
        end else if (calc_enable) begin
            dp_cnt++;
            if (!calc_data[0][0][31] && dp_cnt >= int'(calc_data[0][0][3:0]) + 1) begin
                calc_done = 1; calc_result = xf(calc_data);
            end
        end
        p_out_data = out_data;
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1 chk_reset_vals();
        reset_model();
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic send_blk(input blk_t d, input string nm);
        int n = 0;
        logic rdy;
        in_data = d; in_valid = 1;
        do begin rdy = in_ready; cycle(); n++; end while (!rdy && n < 200);
        in_valid = 0;
        n_vec++;
        if (!rdy) begin n_err++; $display("FAIL %s: block not accepted in %0d cycles", nm, n); end
    endtask

    task automatic wait_idle(input int max, input string nm);
        int n = 0;
        in_valid = 0;
        do begin cycle(); n++; end while (busy && n < max);
        n_vec++;
        if (busy) begin n_err++; $display("FAIL %s: still busy after %0d cycles", nm, n); end
    endtask

    initial begin
        int low, first_en, first_ov, en, f0, n;
        logic seen_ov;
        blk_t d;

        // Power-on reset
        reset_model();
        #1 chk_reset_vals();
        @(negedge clk);
        rst_n = 1;

        // 1: single block, pinned latency and result
        out_ready = 1;
        in_data = mk(0); in_valid = 1;
        cycle();
        in_valid = 0;
        low = 0; first_en = 0; first_ov = 0;
        for (int k = 2; k <= 12; k++) begin
            cycle();
            if (!calc_reset) low++;
            if (calc_enable && first_en == 0) first_en = k;
            if (out_valid && first_ov == 0) first_ov = k;
        end
        chk("t1_flush_len", 32'(low), 2);
        chk("t1_enable_cycle", 32'(first_en), 4);
        chk("t1_valid_cycle", 32'(first_ov), 5);
        chk("t1_count", 32'(block_count), 1);
        chk("t1_out00", out_data[0][0], 32'hDEADBEEF);
        chk("t1_out10", out_data[1][0], 32'hDEADBEEE);

        // 2: three back-to-back blocks
        do_reset();
        f0 = n_flush;
        send_blk(mk(0), "t2_b0");
        send_blk(mk(100), "t2_b1");
        send_blk(mk(200), "t2_b2");
        wait_idle(200, "t2_drain");
        chk("t2_flushes", 32'(n_flush - f0), 3);
        chk("t2_count", 32'(block_count), 3);

        // 3: output back-pressure longer than the timeout
        do_reset();
        out_ready = 0;
        d = '0; for (int i = 0; i < 64; i++) d[i/8][i%8] = 32'h11;
        send_blk(d, "t3_b0");
        d = '0; for (int i = 0; i < 64; i++) d[i/8][i%8] = 32'h22;
        send_blk(d, "t3_b1");
        for (int i = 0; i < 80; i++) cycle();
        chk("t3_held_valid", 32'(out_valid), 1);
        chk("t3_held_run", 32'(calc_enable), 1);
        chk("t3_no_timeout", 32'(err_timeout), 0);
        chk("t3_held_data", out_data[0][0], 32'hDEADBEFE);
        out_ready = 1;
        wait_idle(50, "t3_drain");
        chk("t3_count", 32'(block_count), 2);
        chk("t3_last_data", out_data[0][0], 32'hDEADBECD);

        // 4: datapath never finishes
        do_reset();
        d = '0; d[0][0] = 32'h8000_0000;
        send_blk(d, "t4_hang");
        en = 0; seen_ov = 0; n = 0;
        do begin
            cycle(); n++;
            if (calc_enable) en++;
            if (out_valid) seen_ov = 1;
        end while (!err_timeout && n < 200);
        chk("t4_run_cycles", 32'(en), 64);
        chk("t4_err", 32'(err_timeout), 1);
        chk("t4_no_output", 32'(seen_ov), 0);
        send_blk(mk(0), "t4_good");
        wait_idle(50, "t4_drain");
        chk("t4_good_count", 32'(block_count), 1);
        chk("t4_err_sticky", 32'(err_timeout), 1);

        // 5: reset during RUN and during OUT_VALID
        do_reset();
        d = mk(0); d[0][0] = 32'hE;
        send_blk(d, "t5_run");
        n = 0;
        while (!calc_enable && n < 50) begin cycle(); n++; end
        chk("t5_reached_run", 32'(calc_enable), 1);
        do_reset();
        cycle();
        chk("t5_ready_after", 32'(in_ready), 1);
        chk("t5_count_after", 32'(block_count), 0);
        send_blk(mk(0), "t5_first");
        wait_idle(50, "t5_drain");
        out_ready = 0;
        send_blk(mk(300), "t5_held");
        n = 0;
        while (!out_valid && n < 50) begin cycle(); n++; end
        chk("t5_reached_valid", 32'(out_valid), 1);
        do_reset();
        cycle();
        chk("t5_ready_after2", 32'(in_ready), 1);
        chk("t5_count_after2", 32'(block_count), 0);
        chk("t5_valid_after2", 32'(out_valid), 0);

        // 6: block counter wrap
        do_reset();
        dut.block_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        out_ready = 1;
        send_blk(mk(7), "t6_blk");
        wait_idle(50, "t6_drain");
        chk("t6_wrap", 32'(block_count), 0);

        // Randomized traffic with stalls and occasional hung blocks
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (!in_valid || in_ready) begin
                in_valid = ($urandom_range(0, 1) == 1);
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        in_data[r][c] = $urandom;
                in_data[0][0][31] = ($urandom_range(0, 9) == 0);
            end
            out_ready = (i % 500 < 70) ? 1'b0 : ($urandom_range(0, 9) < 7);
            cycle();
        end
        out_ready = 1;
        wait_idle(300, "rand_drain");
        chk("rand_sb_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
